// File: rtl/flag_marker.sv
// flag_marker: writer side of the per-level flag (defuse) arrays.
// A right-click at a mouse pixel is mapped onto a board cell by repeated
// subtraction of the button size, then that cell's flag bit is toggled.
// Optional build macro FLAG_LIMIT_EN: when defined, flags_left tracks the
// per-level flag budget and a flag can only be placed while budget remains;
// when undefined, flags_left stays 0 and every toggle simply inverts the bit.
module flag_marker #(
    parameter int MINES_EASY   = 10,
    parameter int MINES_MEDIUM = 15,
    parameter int MINES_HARD   = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         level,
    input  logic [11:0]        board_xpos,
    input  logic [11:0]        board_ypos,
    input  logic [11:0]        button_size,
    input  logic [4:0]         button_num,
    input  logic [11:0]        mouse_xpos,
    input  logic [11:0]        mouse_ypos,
    input  logic               right,
    input  logic               game_active,
    input  logic               clear,
    output logic [7:0][7:0]    defuse_arr_easy,
    output logic [9:0][9:0]    defuse_arr_medium,
    output logic [15:0][15:0]  defuse_arr_hard,
    output logic [7:0]         flags_left,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, CHECK, LOC_X, LOC_Y, TOGGLE} state_t;

    state_t             state_q, state_d;
    // [0] first sync stage, [1] synchronized button, [2] previous value for edge detect
    logic [2:0]         sync_q, sync_d;
    logic [11:0]        x_q, x_d, y_q, y_d;
    logic [11:0]        bx_q, bx_d, by_q, by_d;
    logic [11:0]        bs_q, bs_d;
    logic [4:0]         bn_q, bn_d;
    logic [1:0]         lvl_q, lvl_d;
    logic [11:0]        rem_q, rem_d;
    logic [4:0]         col_q, col_d, row_q, row_d;
    logic [7:0]         flags_q, flags_d;
    logic [7:0][7:0]    easy_q, easy_d;
    logic [9:0][9:0]    med_q, med_d;
    logic [15:0][15:0]  hard_q, hard_d;

    logic               click;
    logic               accept;
    logic [11:0]        dx, dy;
    logic [16:0]        span;
    logic               out_of_range;
    logic               cur_bit;
    logic               in_dim;
    logic               new_bit;
    logic               write_en;
`ifdef FLAG_LIMIT_EN
    logic [7:0]         budget;
`endif

    assign click  = sync_q[1] & ~sync_q[2];
    assign accept = click && (state_q == IDLE) && game_active && (level != 2'd0) && !clear;

    // Offsets are only meaningful once the range check has passed.
    assign dx   = x_q - bx_q;
    assign dy   = y_q - by_q;
    assign span = 17'(bn_q) * 17'(bs_q);
    assign out_of_range = (x_q < bx_q) || (y_q < by_q) ||
                          ({5'd0, dx} >= span) || ({5'd0, dy} >= span);

    assign defuse_arr_easy   = easy_q;
    assign defuse_arr_medium = med_q;
    assign defuse_arr_hard   = hard_q;
    assign flags_left        = flags_q;
    assign busy              = (state_q != IDLE);

    // Shift the raw button through the synchronizer and edge-detect register.
    always_comb begin
        sync_d = {sync_q[1:0], right};
    end

`ifdef FLAG_LIMIT_EN
    // Budget loaded on clear, chosen by the live level input.
    always_comb begin
        budget = 8'd0;
        case (level)
            2'd1:    budget = 8'(MINES_EASY);
            2'd2:    budget = 8'(MINES_MEDIUM);
            2'd3:    budget = 8'(MINES_HARD);
            default: budget = 8'd0;
        endcase
    end
`endif

    // Read the flag bit of the located cell; cells outside the array are ignored.
    always_comb begin
        cur_bit = 1'b0;
        in_dim  = 1'b0;
        case (lvl_q)
            2'd1: if (col_q < 5'd8 && row_q < 5'd8) begin
                in_dim  = 1'b1;
                cur_bit = easy_q[col_q[2:0]][row_q[2:0]];
            end
            2'd2: if (col_q < 5'd10 && row_q < 5'd10) begin
                in_dim  = 1'b1;
                cur_bit = med_q[col_q[3:0]][row_q[3:0]];
            end
            2'd3: if (col_q < 5'd16 && row_q < 5'd16) begin
                in_dim  = 1'b1;
                cur_bit = hard_q[col_q[3:0]][row_q[3:0]];
            end
            default: begin
                in_dim  = 1'b0;
                cur_bit = 1'b0;
            end
        endcase
    end

    // Next-state logic: click FSM, cell locator, flag update, and clear override.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        bx_d     = bx_q;
        by_d     = by_q;
        bs_d     = bs_q;
        bn_d     = bn_q;
        lvl_d    = lvl_q;
        rem_d    = rem_q;
        col_d    = col_q;
        row_d    = row_q;
        flags_d  = flags_q;
        easy_d   = easy_q;
        med_d    = med_q;
        hard_d   = hard_q;
        new_bit  = cur_bit;
        write_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Snapshot everything so later input changes cannot disturb this click.
                    x_d     = mouse_xpos;
                    y_d     = mouse_ypos;
                    bx_d    = board_xpos;
                    by_d    = board_ypos;
                    bs_d    = button_size;
                    bn_d    = button_num;
                    lvl_d   = level;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (out_of_range) begin
                    state_d = IDLE;
                end else begin
                    col_d   = 5'd0;
                    rem_d   = dx;
                    state_d = LOC_X;
                end
            end
            LOC_X: begin
                // >= puts a pixel sitting exactly on a cell boundary into the higher cell.
                if (rem_q >= bs_q) begin
                    rem_d = rem_q - bs_q;
                    col_d = col_q + 5'd1;
                end else begin
                    rem_d   = dy;
                    row_d   = 5'd0;
                    state_d = LOC_Y;
                end
            end
            LOC_Y: begin
                if (rem_q >= bs_q) begin
                    rem_d = rem_q - bs_q;
                    row_d = row_q + 5'd1;
                end else begin
                    state_d = TOGGLE;
                end
            end
            TOGGLE: begin
                state_d  = IDLE;
                write_en = 1'b1;
`ifdef FLAG_LIMIT_EN
                if (cur_bit) begin
                    new_bit = 1'b0;
                    if (flags_q != 8'd255) flags_d = flags_q + 8'd1;
                end else if (flags_q != 8'd0) begin
                    new_bit = 1'b1;
                    flags_d = flags_q - 8'd1;
                end else begin
                    new_bit = cur_bit;
                end
`else
                new_bit = ~cur_bit;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (write_en && in_dim) begin
            case (lvl_q)
                2'd1:    easy_d[col_q[2:0]][row_q[2:0]] = new_bit;
                2'd2:    med_d[col_q[3:0]][row_q[3:0]]  = new_bit;
                2'd3:    hard_d[col_q[3:0]][row_q[3:0]] = new_bit;
                default: ;
            endcase
        end

        // New game wins over anything in flight, including a same-cycle toggle.
        if (clear) begin
            state_d = IDLE;
            easy_d  = '0;
            med_d   = '0;
            hard_d  = '0;
`ifdef FLAG_LIMIT_EN
            flags_d = budget;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bs_q    <= '0;
            bn_q    <= '0;
            lvl_q   <= '0;
            rem_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            flags_q <= '0;
            easy_q  <= '0;
            med_q   <= '0;
            hard_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bs_q    <= bs_d;
            bn_q    <= bn_d;
            lvl_q   <= lvl_d;
            rem_q   <= rem_d;
            col_q   <= col_d;
            row_q   <= row_d;
            flags_q <= flags_d;
            easy_q  <= easy_d;
            med_q   <= med_d;
            hard_q  <= hard_d;
        end
    end

endmodule

// File: doc/flag_marker.md
Name: flag_marker

Overview:
- Writer side of the per-level defuse (flag) arrays consumed by the board redraw stage.
- Converts a right-click at a mouse pixel position into a board cell index by iterative subtraction.
- Toggles that cell's flag bit and keeps a remaining-flag counter.
- Sits between the mouse/game-control logic and the board drawing pipeline.

Parameters:
MINES_EASY, 10, flag budget loaded for level 1 (8x8)
MINES_MEDIUM, 15, flag budget loaded for level 2 (10x10)
MINES_HARD, 40, flag budget loaded for level 3 (16x16)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
level  input  2  0 = no game, 1 = easy, 2 = medium, 3 = hard
gin  input  game_set_if.in  uses board_xpos, board_ypos, button_size, button_num
mouse_xpos  input  12  mouse pixel x
mouse_ypos  input  12  mouse pixel y
right  input  1  raw right mouse button, asynchronous to clk
game_active  input  1  clicks accepted only when high
clear  input  1  synchronous new-game clear, one-cycle pulse
defuse_arr_easy  output  [7:0][7:0]  flag bits, indexed [col][row]
defuse_arr_medium  output  [9:0][9:0]  flag bits, indexed [col][row]
defuse_arr_hard  output  [15:0][15:0]  flag bits, indexed [col][row]
flags_left  output  8  remaining flag budget
busy  output  1  high while a click is being processed

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all arrays 0, flags_left 0, busy 0, FSM state IDLE, synchronizer flops 0.
- Input conditioning: right passes through a 2-flop synchronizer, then a rising-edge detector (one register).
- A click is accepted only when all hold: state IDLE, game_active = 1, level != 0, clear = 0.
- On accept, latch mouse_xpos, mouse_ypos, level, button_size, button_num, board_xpos, board_ypos. Later input changes do not affect the operation in progress.
- FSM states: IDLE, CHECK, LOC_X, LOC_Y, TOGGLE.
- IDLE -> CHECK on accept; busy rises the next cycle.
- CHECK (1 cycle):
  - dx = x - board_xpos, dy = y - board_ypos, computed 12-bit after a range check.
  - Out of range when x < board_xpos, y < board_ypos, or dx/dy >= button_num * button_size.
  - Out of range -> IDLE with no change. Otherwise -> LOC_X with col = 0, rem = dx.
- LOC_X: one step per cycle.
  - While rem >= button_size: rem -= button_size, col++.
  - Otherwise load rem = dy, row = 0, go to LOC_Y.
- LOC_Y: same stepping on row; then -> TOGGLE.
- Cell k covers offsets [k*bs, (k+1)*bs-1], so a pixel on a boundary belongs to the higher cell.
- TOGGLE (1 cycle), on the array selected by the latched level:
  - If the bit is 1: clear it; flags_left++ (saturate at 255).
  - Else if flags_left > 0: set it; flags_left--.
  - Else: no change.
  - Then -> IDLE; busy falls.
- Latency: the array update is visible at most 2 + 1 + 1 + button_num + button_num + 2 cycles after right rises. Hard level: <= 38 cycles.
- Click edges seen while busy are dropped, not queued.
- clear (any state): the next cycle all three arrays go to 0, FSM to IDLE, busy to 0.
  - flags_left loads MINES_x for the current level input; level 0 loads 0.
  - clear takes priority over TOGGLE in the same cycle.
- A level change without clear does not touch the arrays or flags_left.
- Only the array for the latched level is ever written. The other arrays hold their values.

Optional Feature:
- Macro: FLAG_LIMIT_EN.
- Defined: flag budget enforced exactly as above.
- Undefined:
  - A flag is set regardless of count.
  - flags_left is tied to 0, and clear does not load it.
  - TOGGLE always inverts the bit.

Test Plan:
- Common setup: level = 1, board_xpos = 100, board_ypos = 100, button_size = 40, button_num = 8, clear pulsed -> flags_left = 10.
- Click at (145,185) -> within 20 cycles defuse_arr_easy[1][2] = 1, flags_left = 9; repeat the click -> bit 0, flags_left = 10.
- Click at (99,150), then at (420,100) (dx = 320 = 8*40) -> no array change, flags_left unchanged, busy back low.
- Click at (140,100) -> boundary pixel maps to col 1, row 0: defuse_arr_easy[1][0] = 1.
- Place 10 flags on distinct cells, then click an 11th cell -> bit stays 0, flags_left = 0. Without FLAG_LIMIT_EN the 11th bit is set.
- Assert clear while state is LOC_X -> arrays all 0, busy 0 next cycle, flags_left = 10. A second right edge during busy -> ignored.
- Set level = 3 with button_num = 16, click the last cell -> defuse_arr_hard[15][15] = 1 within 38 cycles; easy and medium arrays unchanged. Drop rst_n mid-operation -> all outputs 0 immediately.
